reg_scoreboard: RTL and testbench
=================================

# reg_scoreboard

Register-hazard scoreboard that generates the pipeline `Stall` signal consumed by the issue/operand stage and its holding registers. Tracks one pending-write bit per architectural register of the 10-entry register file. Stalls an issuing instruction whose source or destination register has an outstanding write. Clears pending bits on writeback, and keeps a saturating stall-cycle counter plus a sticky protocol-error flag.

## Interface
- `NREGS`, 10, number of architectural registers tracked (2..16)
- `IDXW`, 4, width of register index fields
- `CNTW`, 16, width of stall-cycle counter

- `clk`  in  1  clock, all state on posedge
- `rst`  in  1  synchronous, active-high reset
- `issue_valid`  in  1  instruction presented for issue this cycle
- `issue_src_a`  in  IDXW  first source register index
- `issue_src_b`  in  IDXW  second source register index
- `issue_wen`  in  1  instruction writes `issue_dst`
- `issue_dst`  in  IDXW  destination register index
- `wb_valid`  in  1  writeback completing this cycle
- `wb_dst`  in  IDXW  register written back
- `stall`  out  1  combinational; hold the issue stage this cycle
- `busy_count`  out  IDXW+1  registered popcount of pending bits
- `stall_cycles`  out  CNTW  registered saturating count of stalled cycles
- `err`  out  1  registered sticky protocol error

## Operation
- State: `pending[NREGS-1:0]`, `busy_count`, `stall_cycles`, `err`.
- Effective pending for lookup: `eff[i] = pending[i] & ~(wb_valid & wb_dst==i)`. Writeback clears the bit in the same cycle, giving write-before-read bypass with zero-cycle hazard release.
- Index `>= NREGS` is never pending in lookup.
- `stall = ~rst & issue_valid & (eff[src_a] | eff[src_b] | (issue_wen & eff[issue_dst]))`. Covers RAW and WAW hazards.
- `fire = ~rst & issue_valid & ~stall`.
- Next pending, per bit i:
  - clear if `wb_valid & wb_dst==i`;
  - then set if `fire & issue_wen & issue_dst==i`.
  - Set wins over clear on the same index in the same cycle.
- `busy_count` = popcount of next pending, registered, so it always equals popcount(`pending`).
- `stall_cycles` increments when `stall`=1 and saturates at 2^CNTW-1. It is never cleared except by `rst`.
- `err` is set, and stays set until `rst`, on any of:
  - `wb_valid` with `wb_dst >= NREGS`;
  - `wb_valid` with `pending[wb_dst]`=0 (spurious writeback);
  - `fire & issue_wen` with `issue_dst >= NREGS`. No pending bit is set in this case.
- Out-of-range source indices do not set `err`; they are treated as constant/zero operands.

## Timing
- Reset values, applied at the posedge with `rst`=1: `pending`=0, `busy_count`=0, `stall_cycles`=0, `err`=0.
- `stall`=0 combinationally while `rst`=1. No fire, set, clear or count happens in a reset cycle, including when reset is asserted mid-operation with pending writes (all pending bits are dropped).
- Hazard latency:
  - A fire with `issue_wen` in cycle N makes a dependent issue in cycle N+1 stall.
  - A `wb_valid` for that register in cycle M releases the stall in cycle M itself (combinational).
- `stall` depends combinationally on the issue inputs, the writeback inputs and registered `pending`. It has no combinational path from `stall` back to any input.
- `issue_*` inputs must be held stable by upstream while `stall`=1. The block does not check this.
- Single writeback port. At most one set and one clear occur per cycle.

## Test plan
- Reset, then issue `dst=3`, `wen=1`; next cycle issue `src_a=3` -> `stall`=1 and `busy_count`=1; hold 4 cycles with no writeback -> `stall_cycles`=4.
- With `pending[3]`=1, drive `wb_valid`, `wb_dst=3` in the same cycle as issue `src_b=3` -> `stall`=0, that issue fires, and `pending[3]`=0 next cycle.
- With `pending[5]`=1, issue `wen=1`, `dst=5`, `src`=0,1 (WAW) -> `stall`=1. In the same cycle as `wb_dst=5`, that issue fires and `pending[5]` stays 1 (set wins); `busy_count` is unchanged.
- Issue `wen=1`, `dst=12` -> fires, no pending bit set, `err`=1 next cycle. Also `wb_valid` with `wb_dst=2` and `pending[2]`=0 -> `err`=1.
- Hold `stall`=1 for 2^CNTW+5 cycles (use `CNTW`=4: 21 cycles) -> `stall_cycles` saturates at 15.
- Set `pending` for registers 1, 4 and 9 (`busy_count`=3), then assert `rst` for one cycle while `issue_valid`=1 -> `stall`=0 during reset; afterwards `pending`=0, `busy_count`=0, `err`=0, and the counter is 0.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus between the issue stage and the register-hazard scoreboard.
// The master drives instructions and writebacks; the scoreboard answers with stall.
interface reg_scoreboard_if #(
  parameter int IDXW = 4
);
  logic            issue_valid;
  logic [IDXW-1:0] issue_src_a;
  logic [IDXW-1:0] issue_src_b;
  logic            issue_wen;
  logic [IDXW-1:0] issue_dst;
  logic            wb_valid;
  logic [IDXW-1:0] wb_dst;
  logic            stall;

  modport master (
    output issue_valid, issue_src_a, issue_src_b, issue_wen, issue_dst,
    output wb_valid, wb_dst,
    input  stall
  );

  modport slave (
    input  issue_valid, issue_src_a, issue_src_b, issue_wen, issue_dst,
    input  wb_valid, wb_dst,
    output stall
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one pending-write bit per register, combinational
// RAW/WAW stall with same-cycle writeback bypass, stall counter and sticky error.
module reg_scoreboard #(
  parameter int NREGS = 10,
  parameter int IDXW  = 4,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              rst,
  reg_scoreboard_if.slave   bus,
  output logic [IDXW:0]     busy_count,
  output logic [CNTW-1:0]   stall_cycles,
  output logic              err
);

  localparam logic [IDXW:0] NREGS_W = (IDXW+1)'(NREGS);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [IDXW:0]    busy_count_q, busy_count_d;
  logic [CNTW-1:0]  stall_cycles_q, stall_cycles_d;
  logic             err_q, err_d;

  logic [NREGS-1:0] eff;
  logic             hz_a, hz_b, hz_d, wb_was_pending;
  logic             wb_oor, dst_oor;
  logic             stall, fire;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    eff            = pending_q;
    hz_a           = 1'b0;
    hz_b           = 1'b0;
    hz_d           = 1'b0;
    wb_was_pending = 1'b0;

    // Writeback releases its register in the same cycle (write-before-read bypass).
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wb_valid && bus.wb_dst == IDXW'(i)) eff[i] = 1'b0;
    end

    // Indices >= NREGS match no entry and therefore read as not pending.
    for (int i = 0; i < NREGS; i++) begin
      if (bus.issue_src_a == IDXW'(i)) hz_a = eff[i];
      if (bus.issue_src_b == IDXW'(i)) hz_b = eff[i];
      if (bus.issue_dst   == IDXW'(i)) hz_d = eff[i];
      if (bus.wb_dst      == IDXW'(i)) wb_was_pending = pending_q[i];
    end

    wb_oor  = {1'b0, bus.wb_dst}    >= NREGS_W;
    dst_oor = {1'b0, bus.issue_dst} >= NREGS_W;

    stall = ~rst & bus.issue_valid & (hz_a | hz_b | (bus.issue_wen & hz_d));
    fire  = ~rst & bus.issue_valid & ~stall;

    // Clear first, then set, so an issue to the register being written back wins.
    pending_d = pending_q;
    for (int i = 0; i < NREGS; i++) begin
      if (bus.wb_valid && bus.wb_dst == IDXW'(i))                  pending_d[i] = 1'b0;
      if (fire && bus.issue_wen && bus.issue_dst == IDXW'(i))      pending_d[i] = 1'b1;
    end

    busy_count_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_count_d = busy_count_d + {{IDXW{1'b0}}, pending_d[i]};
    end

    stall_cycles_d = stall_cycles_q;
    if (stall && stall_cycles_q != {CNTW{1'b1}}) stall_cycles_d = stall_cycles_q + CNTW'(1);

    err_d = err_q
          | (bus.wb_valid & (wb_oor | ~wb_was_pending))
          | (fire & bus.issue_wen & dst_oor);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q      <= '0;
      busy_count_q   <= '0;
      stall_cycles_q <= '0;
      err_q          <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      busy_count_q   <= busy_count_d;
      stall_cycles_q <= stall_cycles_d;
      err_q          <= err_d;
    end
  end

  assign bus.stall    = stall;
  assign busy_count   = busy_count_q;
  assign stall_cycles = stall_cycles_q;
  assign err          = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver runs a behavioural model and queues
// expected responses; an independent monitor pops and compares every cycle.
module tb_reg_scoreboard;
  localparam int NREGS = 10;
  localparam int IDXW  = 4;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IDXW:0]   busy_count;
  logic [CNTW-1:0] stall_cycles;
  logic            err;

  reg_scoreboard_if #(.IDXW(IDXW)) bus ();

  reg_scoreboard #(.NREGS(NREGS), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy_count   (busy_count),
    .stall_cycles (stall_cycles),
    .err          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   stall;
    int   busy;
    int   cyc;
    int   err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_pushed = 0;
  int   n_seen   = 0;

  // Reference model: set of registers with outstanding writes, plus counters.
  bit   pend[16];
  int   m_cnt   = 0;
  bit   m_err   = 1'b0;
  bit   m_stall = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic bit hazard(input int r, input bit wbv, input int wbd);
    return (r < NREGS) && pend[r] && !(wbv && wbd == r);
  endfunction

  task automatic step(input bit r, input bit iv, input int a, input int b,
                      input bit wen, input int d, input bit wbv, input int wbd);
    exp_t e;
    bit   st;
    bit   fire;
    int   busy;
    @(posedge clk);
    #1;
    rst             = r;
    bus.issue_valid = iv;
    bus.issue_src_a = IDXW'(a);
    bus.issue_src_b = IDXW'(b);
    bus.issue_wen   = wen;
    bus.issue_dst   = IDXW'(d);
    bus.wb_valid    = wbv;
    bus.wb_dst      = IDXW'(wbd);

    if (r) begin
      st = 1'b0;
      foreach (pend[i]) pend[i] = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
    end else begin
      st   = iv && (hazard(a, wbv, wbd) || hazard(b, wbv, wbd) || (wen && hazard(d, wbv, wbd)));
      fire = iv && !st;
      if (wbv && (wbd >= NREGS || !pend[wbd])) m_err = 1'b1;
      if (fire && wen && d >= NREGS)           m_err = 1'b1;
      if (wbv && wbd < NREGS)                  pend[wbd] = 1'b0;
      if (fire && wen && d < NREGS)            pend[d] = 1'b1;
      if (st && m_cnt < CMAX)                  m_cnt++;
    end
    busy = 0;
    for (int i = 0; i < NREGS; i++) busy += int'(pend[i]);
    m_stall = st;

    e.stall = int'(st);
    e.busy  = busy;
    e.cyc   = m_cnt;
    e.err   = int'(m_err);
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Monitor: stall is checked mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", int'(bus.stall), e.stall);
        @(posedge clk);
        #2;
        check("busy_count", int'(busy_count), e.busy);
        check("stall_cycles", int'(stall_cycles), e.cyc);
        check("err", int'(err), e.err);
        n_seen++;
      end
    end
  end

  initial begin
    int a, b, d;
    bit iv, wen;
    a = 0; b = 0; d = 0; iv = 1'b0; wen = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_src_a = '0;
    bus.issue_src_b = '0;
    bus.issue_wen   = 1'b0;
    bus.issue_dst   = '0;
    bus.wb_valid    = 1'b0;
    bus.wb_dst      = '0;

    // Reset, RAW hazard held four cycles.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 3, 0, 0);
    repeat (4) step(0, 1, 3, 0, 0, 0, 0, 0);
    // Same-cycle writeback releases the hazard.
    step(0, 1, 0, 3, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // WAW stall, then fire alongside writeback of the same register.
    step(0, 1, 0, 0, 1, 5, 0, 0);
    step(0, 1, 0, 1, 1, 5, 0, 0);
    step(0, 1, 0, 1, 1, 5, 1, 5);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Out-of-range destination, then spurious writeback after a reset.
    step(0, 1, 0, 0, 1, 12, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // Counter saturation.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 7, 0, 0);
    repeat (21) step(0, 1, 7, 7, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7);
    // Mid-operation reset with pending writes and an issue presented.
    step(0, 1, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1, 4, 0, 0);
    step(0, 1, 0, 0, 1, 9, 0, 0);
    step(1, 1, 1, 4, 1, 9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 4, 1, 9, 0, 0);

    // Randomized traffic; issue fields are held while the model says stall.
    for (int k = 0; k < 600; k++) begin
      bit r;
      bit wbv;
      int wbd;
      int cand[$];
      r = ($urandom_range(0, 79) == 0);
      if (!m_stall) begin
        iv  = ($urandom_range(0, 3) != 0);
        a   = $urandom_range(0, 15);
        b   = $urandom_range(0, 15);
        wen = 1'($urandom_range(0, 1));
        d   = ($urandom_range(0, 9) == 0) ? $urandom_range(NREGS, 15) : $urandom_range(0, NREGS - 1);
      end
      wbv = ($urandom_range(0, 2) == 0);
      cand.delete();
      for (int i = 0; i < NREGS; i++) if (pend[i]) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(0, 9) != 0)
        wbd = cand[$urandom_range(0, cand.size() - 1)];
      else
        wbd = $urandom_range(0, 15);
      step(r, iv, a, b, wen, d, wbv, wbd);
    end

    step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);
    check("items_seen", n_seen, n_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
